// File: rtl/core_if_fetch_ctrl.sv
// Instruction fetch control: one outstanding memory request, single-entry
// output buffer toward ID, redirect from EX with stale-response dropping.
module core_if_fetch_ctrl #(
  parameter int CORE_PC_WIDTH = 32,
  parameter logic [CORE_PC_WIDTH-1:0] RESET_PC = CORE_PC_WIDTH'(32'h8000_0000)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     branch_jump,
  input  logic [CORE_PC_WIDTH-1:0] bj_pc,
  output logic                     ifu_req_valid,
  output logic [CORE_PC_WIDTH-1:0] ifu_req_addr,
  input  logic                     ifu_req_ready,
  input  logic                     ifu_rsp_valid,
  input  logic [31:0]              ifu_rsp_inst,
  output logic                     if_id_valid,
  output logic [CORE_PC_WIDTH-1:0] if_id_pc,
  output logic [31:0]              if_id_inst,
  input  logic                     if_id_ready,
  output logic                     flush_out
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic [CORE_PC_WIDTH-1:0] pc_q, pc_d;
  logic                     drop_q, drop_d;
  logic                     flush_q;
  logic                     buf_ld;
  logic [CORE_PC_WIDTH-1:0] buf_pc_q;
  logic [31:0]              buf_inst_q;
  logic [CORE_PC_WIDTH-1:0] bj_tgt;

  assign bj_tgt       = {bj_pc[CORE_PC_WIDTH-1:2], 2'b00};
  assign ifu_req_addr = pc_q;
  assign if_id_pc     = buf_pc_q;
  assign if_id_inst   = buf_inst_q;
  assign flush_out    = flush_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    buf_ld        = 1'b0;
    ifu_req_valid = 1'b0;
    if_id_valid   = 1'b0;
    if (branch_jump) begin
      // Redirect wins; a response in flight is either eaten now or later.
      pc_d = bj_tgt;
      unique case (state_q)
        S_WAIT: begin
          if (ifu_rsp_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
        S_OUT:   state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          ifu_req_valid = 1'b1;
          if (ifu_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (ifu_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              buf_ld  = 1'b1;
              pc_d    = pc_q + CORE_PC_WIDTH'(4);
              state_d = S_OUT;
            end
          end
        end
        S_OUT: begin
          if_id_valid = 1'b1;
          if (if_id_ready) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
    if (!rst_n) begin
      ifu_req_valid = 1'b0;
      if_id_valid   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      flush_q <= branch_jump;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_ld) begin
      buf_pc_q   <= pc_q;
      buf_inst_q <= ifu_rsp_inst;
    end
  end

endmodule

// File: tb/tb_core_if_fetch_ctrl.sv
// Randomized bench for core_if_fetch_ctrl against a transaction-level
// model of the fetch stream and a variable-latency instruction memory.
module tb_core_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_jump;
  logic [31:0] bj_pc;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_ready;
  logic        flush_out;

  core_if_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_jump  (branch_jump),
    .bj_pc        (bj_pc),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_addr (ifu_req_addr),
    .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_inst (ifu_rsp_inst),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_inst   (if_id_inst),
    .if_id_ready  (if_id_ready),
    .flush_out    (flush_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int id_hs  = 0;

  // fetch-stream model
  logic [31:0] exp_pc;
  bit          pending;
  bit          drop;
  bit          holding;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  bit          prev_bj;

  // memory model
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc   = RST_PC;
    pending  = 0;
    drop     = 0;
    holding  = 0;
    prev_bj  = 0;
    mem_busy = 0;
    mem_cnt  = 0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n         = 1'b0;
      branch_jump   = 1'b0;
      bj_pc         = $urandom;
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'b0;
      ifu_rsp_inst  = $urandom;
      if_id_ready   = 1'b1;
      #1;
      chk("rst_req_valid", ifu_req_valid, 0);
      chk("rst_id_valid", if_id_valid, 0);
      if (i > 0) chk("rst_flush", flush_out, 0);
    end
    model_reset();
  endtask

  task automatic cyc(input int pbj, input int pr, input int pid,
                     input int lat, input bit force_bj,
                     input logic [31:0] tgt);
    bit bj, rv, req_hs, rsp;
    @(negedge clk);
    rst_n         = 1'b1;
    rsp           = mem_busy && mem_cnt == 0;
    ifu_rsp_valid = rsp;
    ifu_rsp_inst  = rsp ? inst_of(mem_addr) : $urandom;
    ifu_req_ready = ($urandom % 100) < pr;
    if_id_ready   = ($urandom % 100) < pid;
    bj            = force_bj || (($urandom % 100) < pbj);
    branch_jump   = bj;
    bj_pc         = force_bj ? tgt : $urandom;
    #1;
    chk("flush", flush_out, prev_bj);
    rv = !bj && !pending && !holding;
    chk("req_valid", ifu_req_valid, rv);
    if (rv) chk("req_addr", ifu_req_addr, exp_pc);
    chk("id_valid", if_id_valid, holding && !bj);
    if (holding && !bj) begin
      chk("id_pc", if_id_pc, hold_pc);
      chk("id_inst", if_id_inst, hold_inst);
    end
    if (if_id_valid && if_id_ready) id_hs++;
    req_hs = rv && ifu_req_ready;
    if (rsp) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (req_hs) begin
      mem_busy = 1;
      mem_cnt  = $urandom_range(0, lat);
      mem_addr = exp_pc;
    end
    prev_bj = bj;
    if (bj) begin
      exp_pc  = {bj_pc[31:2], 2'b00};
      holding = 0;
      if (pending) begin
        if (rsp) begin
          pending = 0;
          drop    = 0;
        end else begin
          drop = 1;
        end
      end
    end else if (req_hs) begin
      pending = 1;
    end else if (pending && rsp) begin
      pending = 0;
      if (drop) begin
        drop = 0;
      end else begin
        holding   = 1;
        hold_pc   = exp_pc;
        hold_inst = ifu_rsp_inst;
        exp_pc    = exp_pc + 32'd4;
      end
    end else if (holding && if_id_ready) begin
      holding = 0;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    branch_jump   = 1'b0;
    bj_pc         = '0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_inst  = '0;
    if_id_ready   = 1'b0;
    model_reset();
    do_reset(3);

    id_hs = 0;
    repeat (30) cyc(0, 100, 100, 0, 0, '0);
    chk("throughput", id_hs, 10);

    do_reset(2);
    cyc(0, 100, 100, 0, 1, 32'hFFFF_FFFF);
    repeat (3) cyc(0, 100, 100, 0, 0, '0);
    chk("wrap_addr", ifu_req_addr, 0);
    repeat (6) cyc(0, 100, 100, 0, 0, '0);

    do_reset(2);
    repeat (2000) cyc(8, 60, 60, 3, 0, '0);
    repeat (1500) cyc(15, 30, 20, 2, 0, '0);
    do_reset(2);
    repeat (1500) cyc(25, 80, 90, 1, 0, '0);
    repeat (500) cyc(3, 100, 100, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_if_fetch_ctrl.md
CORE_IF_FETCH_CTRL -- requirements
Module: core_if_fetch_ctrl

Interface
REQ-001 Parameter CORE_PC_WIDTH, default 32, SHALL set the width of the PC and of all address ports.
REQ-002 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 branch_jump  input  1  SHALL be the redirect strobe from the EX branch/jump unit, valid for one cycle.
REQ-006 bj_pc  input  CORE_PC_WIDTH  SHALL be the redirect target, sampled only when branch_jump=1.
REQ-007 ifu_req_valid  output  1  SHALL indicate a fetch request to instruction memory.
REQ-008 ifu_req_addr  output  CORE_PC_WIDTH  SHALL be the fetch address, equal to pc_r.
REQ-009 ifu_req_ready  input  1  SHALL indicate memory accepts the request; handshake = valid & ready.
REQ-010 ifu_rsp_valid  input  1  SHALL indicate a returned instruction; memory never returns one without an accepted request.
REQ-011 ifu_rsp_inst  input  32  SHALL be the returned instruction word.
REQ-012 if_id_valid  output  1  SHALL indicate a valid instruction to ID.
REQ-013 if_id_pc  output  CORE_PC_WIDTH  SHALL be the PC of the presented instruction.
REQ-014 if_id_inst  output  32  SHALL be the presented instruction.
REQ-015 if_id_ready  input  1  SHALL indicate ID accepts; handshake = valid & ready.
REQ-016 flush_out  output  1  SHALL pulse high for exactly the cycle after any branch_jump=1 (registered), killing younger stages.

Function
REQ-017 State machine SHALL have states REQ, WAIT, OUT; at most one memory request outstanding.
REQ-018 REQ: ifu_req_valid=1 when branch_jump=0; on handshake -> WAIT; pc_r held while waiting for ready.
REQ-019 ifu_req_addr SHALL remain stable while ifu_req_valid=1 and ifu_req_ready=0.
REQ-020 WAIT: on ifu_rsp_valid with drop_r=0, capture {pc_r, inst} into output buffer, pc_r <= pc_r+4, -> OUT.
REQ-021 OUT: if_id_valid=1 with buffered pc/inst; on ID handshake -> REQ.
REQ-022 Minimum throughput SHALL be one instruction per 3 cycles (zero-wait memory, ID always ready).
REQ-023 pc_r+4 SHALL wrap modulo 2^CORE_PC_WIDTH.
REQ-024 On branch_jump=1: pc_r <= {bj_pc[W-1:2],2'b00} at the next edge, regardless of state.
REQ-025 Redirect in REQ: ifu_req_valid forced 0 that cycle (no handshake with stale PC); stay REQ.
REQ-026 Redirect in WAIT, no rsp that cycle: set drop_r, stay WAIT; next response discarded, clear drop_r, -> REQ, pc_r not incremented.
REQ-027 Redirect in WAIT with ifu_rsp_valid same cycle: response discarded, -> REQ, drop_r stays 0.
REQ-028 Redirect in OUT: if_id_valid forced 0 that cycle; buffer invalidated; -> REQ (ID handshake that cycle impossible).
REQ-029 branch_jump SHALL take priority over every other event in the same cycle.
REQ-030 A discarded response SHALL never reach if_id_* and SHALL never increment pc_r.

Reset
REQ-031 rst_n=0 at an edge: state=REQ, pc_r=RESET_PC, drop_r=0, buffer invalid, flush_out=0.
REQ-032 During reset cycles ifu_req_valid=0, if_id_valid=0; outstanding request at reset is abandoned; memory is reset with the core.
REQ-033 First request SHALL issue in the first cycle with rst_n=1, addr=RESET_PC.

Verification
REQ-034 Reset release, zero-wait memory, ID ready -> requests at 0x80000000, 0x80000004, 0x80000008; if_id_valid every 3rd cycle with matching pc.
REQ-035 ifu_req_ready low 4 cycles -> addr stable 0x80000000 throughout; single handshake then WAIT.
REQ-036 branch_jump=1, bj_pc=0x80000103 in WAIT, response 2 cycles later -> response dropped, flush_out one-cycle pulse, next request addr 0x80000100.
REQ-037 branch_jump with ifu_rsp_valid same cycle -> no if_id_valid, next request at new target, drop_r=0.
REQ-038 pc_r=0xFFFFFFFC fetch completes -> next request addr 0x00000000.
REQ-039 if_id_ready low 5 cycles in OUT, then branch_jump -> instruction never accepted, if_id_valid drops, fetch resumes at bj_pc.
